cmat_dot_engine: RTL and testbench

- Downstream consumer of the complex matrix RAM bank (four single-port RAMs: M1 real/imag, M2 real/imag, one matrix row per address).
- Sequences row addresses into both matrices and computes every complex dot product C[i][j] = sum_k M1[i][k]*M2[j][k].
- M2 is stored transposed, so RAM row j of M2 holds column j of the right-hand operand.
- Streams one full-precision complex result per cycle to the result sink.

---
 rtl/cmat_dot_engine_if.sv | 37 +++
 rtl/cmat_dot_engine.sv | 139 +++++++++++++
 tb/tb_cmat_dot_engine.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmat_dot_engine_if.sv
// Bundle between the complex matrix dot-product engine, its RAM bank and its result sink.
// The engine uses the slave view; the requester/RAM side uses the master view.
interface cmat_dot_engine_if #(
    parameter int unsigned WORD_LEN   = 16,
    parameter int unsigned MATRIX_DIM = 4,
    parameter int unsigned ADDR_BITS  = 2
);
    localparam int unsigned ACC_W = 2 * WORD_LEN + $clog2(MATRIX_DIM) + 1;
    localparam int unsigned ROW_W = WORD_LEN * MATRIX_DIM;

    logic                    start;
    logic                    busy;
    logic                    done;
    logic [ADDR_BITS-1:0]    dir_m1;
    logic [ADDR_BITS-1:0]    dir_m2;
    logic [ROW_W-1:0]        br_m1;
    logic [ROW_W-1:0]        bi_m1;
    logic [ROW_W-1:0]        br_m2;
    logic [ROW_W-1:0]        bi_m2;
    logic signed [ACC_W-1:0] res_real;
    logic signed [ACC_W-1:0] res_imag;
    logic [ADDR_BITS-1:0]    res_row;
    logic [ADDR_BITS-1:0]    res_col;
    logic                    res_valid;

    modport master (
        output start, br_m1, bi_m1, br_m2, bi_m2,
        input  busy, done, dir_m1, dir_m2,
        input  res_real, res_imag, res_row, res_col, res_valid
    );

    modport slave (
        input  start, br_m1, bi_m1, br_m2, bi_m2,
        output busy, done, dir_m1, dir_m2,
        output res_real, res_imag, res_row, res_col, res_valid
    );
endinterface

// File: rtl/cmat_dot_engine.sv
// Streams every complex dot product C[i][j] = sum_k M1[i][k]*M2[j][k] from a row-per-address
// RAM bank, one full-precision result per cycle, three cycles after the row addresses.
module cmat_dot_engine #(
    parameter int unsigned WORD_LEN   = 16,
    parameter int unsigned MATRIX_DIM = 4,
    parameter int unsigned ADDR_BITS  = 2
) (
    input logic              clk,
    input logic              rst,
    cmat_dot_engine_if.slave bus
);
    localparam int unsigned ACC_W  = 2 * WORD_LEN + $clog2(MATRIX_DIM) + 1;
    localparam int unsigned PROD_W = 2 * WORD_LEN;
    localparam int unsigned ROW_W  = WORD_LEN * MATRIX_DIM;
    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(MATRIX_DIM - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state, state_nxt;

    logic [ADDR_BITS-1:0] row_q, col_q;
    logic                 a_valid, b_valid, res_valid_q, done_q, busy_q;
    logic [ADDR_BITS-1:0] a_row, a_col, b_row, b_col, res_row_q, res_col_q;

    logic signed [PROD_W-1:0] p_rr [MATRIX_DIM];
    logic signed [PROD_W-1:0] p_ii [MATRIX_DIM];
    logic signed [PROD_W-1:0] p_ri [MATRIX_DIM];
    logic signed [PROD_W-1:0] p_ir [MATRIX_DIM];

    logic signed [ACC_W-1:0] sum_re_c, sum_im_c, res_re_q, res_im_q;
    logic                    last_issue_c;

    // Sign-extended lane k of a packed RAM row.
    function automatic logic signed [PROD_W-1:0] lane(input logic [ROW_W-1:0] v, input int unsigned k);
        lane = PROD_W'($signed(v[k*WORD_LEN +: WORD_LEN]));
    endfunction

    assign last_issue_c = (row_q == LAST) && (col_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)    state_nxt = ISSUE;
            ISSUE:   if (last_issue_c) state_nxt = DRAIN;
            DRAIN:   if (done_q)       state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Row/column issue counters double as the RAM addresses; j is the fast index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (state == IDLE && bus.start) begin
            row_q <= '0;
            col_q <= '0;
        end else if (state == ISSUE) begin
            if (col_q == LAST) begin
                col_q <= '0;
                row_q <= (row_q == LAST) ? '0 : ADDR_BITS'(row_q + 1'b1);
            end else begin
                col_q <= ADDR_BITS'(col_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid     <= 1'b0;
            b_valid     <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            a_row       <= '0;
            a_col       <= '0;
            b_row       <= '0;
            b_col       <= '0;
            res_row_q   <= '0;
            res_col_q   <= '0;
            res_re_q    <= '0;
            res_im_q    <= '0;
            for (int k = 0; k < MATRIX_DIM; k++) begin
                p_rr[k] <= '0;
                p_ii[k] <= '0;
                p_ri[k] <= '0;
                p_ir[k] <= '0;
            end
        end else begin
            busy_q      <= (state_nxt != IDLE);
            a_valid     <= (state == ISSUE);
            a_row       <= row_q;
            a_col       <= col_q;
            b_valid     <= a_valid;
            b_row       <= a_row;
            b_col       <= a_col;
            res_valid_q <= b_valid;
            done_q      <= b_valid && (b_row == LAST) && (b_col == LAST);
            // RAM data is present while a_valid is high; register the lane products.
            for (int k = 0; k < MATRIX_DIM; k++) begin
                p_rr[k] <= lane(bus.br_m1, k) * lane(bus.br_m2, k);
                p_ii[k] <= lane(bus.bi_m1, k) * lane(bus.bi_m2, k);
                p_ri[k] <= lane(bus.br_m1, k) * lane(bus.bi_m2, k);
                p_ir[k] <= lane(bus.bi_m1, k) * lane(bus.br_m2, k);
            end
            if (b_valid) begin
                res_re_q  <= sum_re_c;
                res_im_q  <= sum_im_c;
                res_row_q <= b_row;
                res_col_q <= b_col;
            end
        end
    end

    // Full-width reduction: ACC_W covers D lanes of signed product differences exactly.
    always_comb begin
        sum_re_c = '0;
        sum_im_c = '0;
        for (int k = 0; k < MATRIX_DIM; k++) begin
            sum_re_c = sum_re_c + ACC_W'(p_rr[k]) - ACC_W'(p_ii[k]);
            sum_im_c = sum_im_c + ACC_W'(p_ri[k]) + ACC_W'(p_ir[k]);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dir_m1    = row_q;
    assign bus.dir_m2    = col_q;
    assign bus.res_real  = res_re_q;
    assign bus.res_imag  = res_im_q;
    assign bus.res_row   = res_row_q;
    assign bus.res_col   = res_col_q;
    assign bus.res_valid = res_valid_q;
endmodule

// File: tb/tb_cmat_dot_engine.sv
// Scoreboard bench for cmat_dot_engine: directed matrices, hand-derived results, RAM model with one-cycle read.
module tb_cmat_dot_engine;
    localparam int unsigned W = 16;
    localparam int unsigned D = 4;
    localparam int unsigned A = 2;

    typedef struct {
        int     row;
        int     col;
        longint re;
        longint im;
        bit     last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    cmat_dot_engine_if #(.WORD_LEN(W), .MATRIX_DIM(D), .ADDR_BITS(A)) bus ();

    cmat_dot_engine #(.WORD_LEN(W), .MATRIX_DIM(D), .ADDR_BITS(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [W-1:0] m1r [D][D];
    logic signed [W-1:0] m1i [D][D];
    logic signed [W-1:0] m2r [D][D];
    logic signed [W-1:0] m2i [D][D];

    // RAM bank: address sampled on the edge, row data valid the following cycle.
    always @(posedge clk) begin
        for (int k = 0; k < D; k++) begin
            bus.br_m1[k*W +: W] <= m1r[bus.dir_m1][k];
            bus.bi_m1[k*W +: W] <= m1i[bus.dir_m1][k];
            bus.br_m2[k*W +: W] <= m2r[bus.dir_m2][k];
            bus.bi_m2[k*W +: W] <= m2i[bus.dir_m2][k];
        end
    end

    exp_t sb [$];
    exp_t mon_e;
    int   mon_pass = 0, mon_total = 0;
    int   n_pass = 0, n_total = 0;
    int   nvalid = 0, ndone = 0;
    int   first_valid_cyc = 0, last_valid_cyc = 0;
    bit   prev_valid = 1'b0;
    int   s_cyc, base_v, base_d;

    // Monitor: every presented result is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.res_valid) begin
                nvalid++;
                if (!prev_valid) first_valid_cyc = cyc;
                last_valid_cyc = cyc;
                if (bus.done) ndone++;
                mon_total++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_result: got (%0d,%0d) re %0d im %0d, required no result",
                             bus.res_row, bus.res_col, bus.res_real, bus.res_imag);
                end else begin
                    mon_e = sb.pop_front();
                    if (int'(bus.res_row) == mon_e.row && int'(bus.res_col) == mon_e.col &&
                        longint'(bus.res_real) == mon_e.re && longint'(bus.res_imag) == mon_e.im &&
                        bus.done == mon_e.last)
                        mon_pass++;
                    else
                        $display("FAIL result: got (%0d,%0d) re %0d im %0d done %0b, required (%0d,%0d) re %0d im %0d done %0b",
                                 bus.res_row, bus.res_col, bus.res_real, bus.res_imag, bus.done,
                                 mon_e.row, mon_e.col, mon_e.re, mon_e.im, mon_e.last);
                end
            end else if (bus.done) begin
                ndone++;
                mon_total++;
                $display("FAIL done_without_valid: got done 1 res_valid 0, required done 0");
            end
            prev_valid = bus.res_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // kind 0: identity test (re = i+j+1); 1: 1+2j . 3-1j; 2: all -32768 complex; 3: -32768 . 32767 real.
    task automatic push_run(input int kind);
        exp_t e;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                e.row  = i;
                e.col  = j;
                e.last = (i == D - 1) && (j == D - 1);
                case (kind)
                    0:       begin e.re = longint'(i + j + 1); e.im = 0; end
                    1:       begin e.re = 20; e.im = 20; end
                    2:       begin e.re = 0; e.im = 64'sd8589934592; end
                    default: begin e.re = -64'sd4294836224; e.im = 0; end
                endcase
                sb.push_back(e);
            end
        end
    endtask

    task automatic load(input int kind);
        for (int r = 0; r < D; r++) begin
            for (int k = 0; k < D; k++) begin
                case (kind)
                    0: begin
                        m1r[r][k] = (r == k) ? 16'sd1 : 16'sd0;
                        m1i[r][k] = 16'sd0;
                        m2r[r][k] = W'(r + k + 1);
                        m2i[r][k] = 16'sd0;
                    end
                    1: begin
                        m1r[r][k] = 16'sd1;
                        m1i[r][k] = 16'sd2;
                        m2r[r][k] = 16'sd3;
                        m2i[r][k] = -16'sd1;
                    end
                    2: begin
                        m1r[r][k] = -16'sd32768;
                        m1i[r][k] = -16'sd32768;
                        m2r[r][k] = -16'sd32768;
                        m2i[r][k] = -16'sd32768;
                    end
                    default: begin
                        m1r[r][k] = -16'sd32768;
                        m1i[r][k] = 16'sd0;
                        m2r[r][k] = 16'sd32767;
                        m2i[r][k] = 16'sd0;
                    end
                endcase
            end
        end
    endtask

    // Pulse start for one cycle; returns inside cycle 1 (the cycle after the request).
    task automatic do_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (ndone < target && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check("done_within_budget", longint'(ndone), longint'(target));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        load(0);
        idle(2);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_done", longint'(bus.done), 0);
        check("rst_res_valid", longint'(bus.res_valid), 0);
        check("rst_dir", longint'({bus.dir_m1, bus.dir_m2}), 0);
        check("rst_res_real", longint'(bus.res_real), 0);
        rst = 1'b0;
        idle(2);

        // Latency and order with identity M1.
        base_v = nvalid; base_d = ndone;
        push_run(0);
        do_start();
        check("busy_cycle1", longint'(bus.busy), 1);
        check("dir_cycle1", longint'({bus.dir_m1, bus.dir_m2}), 0);
        idle(1);
        check("dir_m2_cycle2", longint'(bus.dir_m2), 1);
        wait_done(base_d + 1);
        check("first_valid_latency", longint'(first_valid_cyc - s_cyc), 4);
        check("last_valid_offset", longint'(last_valid_cyc - s_cyc), 19);
        check("valid_count", longint'(nvalid - base_v), 16);
        idle(3);
        check("busy_after_run", longint'(bus.busy), 0);
        check("res_hold", longint'(bus.res_real), 7);
        check("sb_empty_1", longint'(sb.size()), 0);

        // Complex arithmetic.
        load(1);
        push_run(1);
        do_start();
        wait_done(ndone + 1);
        idle(2);

        // Width extremes.
        load(2);
        push_run(2);
        do_start();
        wait_done(ndone + 1);
        idle(2);
        load(3);
        push_run(3);
        do_start();
        wait_done(ndone + 1);
        idle(2);
        check("sb_empty_2", longint'(sb.size()), 0);

        // Start while busy, including on the done cycle.
        load(1);
        push_run(1);
        base_v = nvalid; base_d = ndone;
        @(posedge clk); #1;
        s_cyc = cyc;
        for (int k = 0; k < 30; k++) begin
            bus.start = (k == 0 || k == 5 || k == 19);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("busy_start_valids", longint'(nvalid - base_v), 16);
        check("busy_start_dones", longint'(ndone - base_d), 1);
        check("busy_start_done_cycle", longint'(last_valid_cyc - s_cyc), 19);
        check("busy_start_idle", longint'(bus.busy), 0);

        // Asynchronous reset mid-run.
        load(0);
        push_run(0);
        base_v = nvalid;
        do_start();
        for (int k = 0; k < 50 && nvalid < base_v + 6; k++) begin
            @(negedge clk); #1;
        end
        check("six_before_abort", longint'(nvalid - base_v), 6);
        #1 rst = 1'b1;
        #1;
        check("abort_res_valid", longint'(bus.res_valid), 0);
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_done", longint'(bus.done), 0);
        sb.delete();
        idle(2);
        rst = 1'b0;
        base_v = nvalid; base_d = ndone;
        idle(10);
        check("abort_no_valid", longint'(nvalid - base_v), 0);
        check("abort_no_done", longint'(ndone - base_d), 0);
        check("abort_idle_busy", longint'(bus.busy), 0);
        push_run(0);
        base_v = nvalid;
        do_start();
        wait_done(ndone + 1);
        check("rerun_valids", longint'(nvalid - base_v), 16);
        idle(2);

        // Back-to-back runs.
        load(1);
        push_run(1);
        push_run(1);
        do_start();
        wait_done(ndone + 1);
        check("busy_on_done", longint'(bus.busy), 1);
        @(posedge clk); #1;
        check("busy_gap", longint'(bus.busy), 0);
        bus.start = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_resume", longint'(bus.busy), 1);
        wait_done(ndone + 1);
        check("b2b_latency", longint'(first_valid_cyc - s_cyc), 4);
        idle(3);
        check("sb_empty_end", longint'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass + mon_pass, n_total + mon_total);
        $finish;
    end
endmodule
